// File: rtl/mult_div_pkg.sv
// Shared encodings for the iterative multiply/divide unit: op codes, FSM states,
// default width. Divide support is gated by MULT_DIV_UNIT_DIV_EN in the users.
package mult_div_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MTHI  = 3'd4,
    OP_MTLO  = 3'd5
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_fsm.sv
// Sequencer for mult_div_unit: state, iteration counter, busy and done.
// The DIV state is only reachable when MULT_DIV_UNIT_DIV_EN is defined.
module mult_div_fsm
  import mult_div_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [2:0] op,
  output state_e     state,
  output logic       busy,
  output logic       done,
  output logic       last
);

  localparam int CW = $clog2(DATA_WIDTH);

  state_e          state_d;
  logic [CW-1:0]   cnt_q;
  logic [CW-1:0]   cnt_d;

  assign last = (cnt_q == CW'(DATA_WIDTH - 1));

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses <= so every register sees pre-edge values.
    if (rst) begin
      state <= ST_IDLE;
      cnt_q <= '0;
    end else begin
      state <= state_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    // NOTE: defaults first, so no path through the case can infer a latch.
    state_d = state;
    cnt_d   = cnt_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state)
      ST_IDLE: begin
        cnt_d = '0;
        if (start && is_mul_op(op)) state_d = ST_MUL;
`ifdef MULT_DIV_UNIT_DIV_EN
        else if (start && is_div_op(op)) state_d = ST_DIV;
`endif
      end
      ST_MUL, ST_DIV: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 1'b1;
        if (last) begin
          state_d = ST_DONE;
          cnt_d   = '0;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/mult_div_unit.sv
// HI/LO multiply/divide unit: shift-add multiply and restoring divide, one bit
// per cycle on magnitudes with sign fix-up on the last step. Divide needs MULT_DIV_UNIT_DIV_EN.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [2:0]            op,
  input  logic [DATA_WIDTH-1:0] A,
  input  logic [DATA_WIDTH-1:0] B,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] hi,
  output logic [DATA_WIDTH-1:0] lo
);

  localparam int W = DATA_WIDTH;

  state_e         state;
  logic           last;

  // upper/lower hold {partial product, multiplier} or {remainder, dividend}.
  logic [W-1:0]   upper_q, lower_q, opnd_q;
  logic           neg_lo_q;

  logic           a_neg, b_neg;
  logic [W-1:0]   a_mag, b_mag;

  logic [W:0]     mul_sum;
  logic [2*W-1:0] prod, prod_fix;

  mult_div_fsm #(.DATA_WIDTH(DATA_WIDTH)) u_fsm (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .state (state),
    .busy  (busy),
    .done  (done),
    .last  (last)
  );

  assign a_neg = is_signed_op(op) & A[W-1];
  assign b_neg = is_signed_op(op) & B[W-1];
  assign a_mag = a_neg ? (~A + 1'b1) : A;
  assign b_mag = b_neg ? (~B + 1'b1) : B;

  assign mul_sum  = {1'b0, upper_q} + ({1'b0, opnd_q} & {(W+1){lower_q[0]}});
  assign prod     = {mul_sum, lower_q[W-1:1]};
  assign prod_fix = neg_lo_q ? (~prod + 1'b1) : prod;

`ifdef MULT_DIV_UNIT_DIV_EN
  logic           neg_hi_q, div0_q;
  logic [W:0]     shifted, diff;
  logic           fits;
  logic [W-1:0]   rem_n, quo_n, rem_fix, quo_fix;

  assign shifted = {upper_q, lower_q[W-1]};
  assign diff    = shifted - {1'b0, opnd_q};
  assign fits    = ~diff[W];
  assign rem_n   = fits ? diff[W-1:0] : shifted[W-1:0];
  assign quo_n   = {lower_q[W-2:0], fits};
  // A zero divisor leaves |A| as the remainder; only the quotient needs forcing.
  assign rem_fix = neg_hi_q ? (~rem_n + 1'b1) : rem_n;
  assign quo_fix = div0_q ? '1 : (neg_lo_q ? (~quo_n + 1'b1) : quo_n);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: iteration registers are cleared too, so an aborted op leaves no residue.
      upper_q  <= '0;
      lower_q  <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
      hi       <= '0;
      lo       <= '0;
`ifdef MULT_DIV_UNIT_DIV_EN
      neg_hi_q <= 1'b0;
      div0_q   <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (is_mul_op(op)) begin
              upper_q  <= '0;
              lower_q  <= b_mag;
              opnd_q   <= a_mag;
              neg_lo_q <= a_neg ^ b_neg;
            end
`ifdef MULT_DIV_UNIT_DIV_EN
            else if (is_div_op(op)) begin
              upper_q  <= '0;
              lower_q  <= a_mag;
              opnd_q   <= b_mag;
              neg_lo_q <= a_neg ^ b_neg;
              neg_hi_q <= a_neg;
              div0_q   <= (B == '0);
            end
`endif
            else if (op == OP_MTHI) hi <= A;
            else if (op == OP_MTLO) lo <= A;
          end
        end
        ST_MUL: begin
          upper_q <= prod[2*W-1:W];
          lower_q <= prod[W-1:0];
          if (last) {hi, lo} <= prod_fix;
        end
`ifdef MULT_DIV_UNIT_DIV_EN
        ST_DIV: begin
          upper_q <= rem_n;
          lower_q <= quo_n;
          if (last) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed cases with literal results,
// then random ops compared every cycle against an arithmetic reference model.
module tb_mult_div_unit;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [2:0]  op;
  logic [31:0] A, B;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int errors = 0;

  mult_div_unit #(.DATA_WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: cycles remaining plus the pending result, computed with plain arithmetic.
  int                 left = 0;
  logic               m_done = 1'b0;
  logic [31:0]        m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
  bit                 model_ok = 1'b0;
  logic signed [63:0] sa, sb, sq, sr;
  logic [63:0]        pr;

  always @(posedge clk) begin
    if (rst) begin
      left = 0; m_done = 1'b0; m_hi = '0; m_lo = '0; model_ok = 1'b1;
    end else if (left > 0) begin
      left--;
      if (left == 0) begin
        m_hi = p_hi; m_lo = p_lo; m_done = 1'b1;
      end
    end else if (m_done) begin
      m_done = 1'b0;
    end else if (start) begin
      case (op)
        3'd0: begin
          sa = {{32{A[31]}}, A}; sb = {{32{B[31]}}, B};
          pr = 64'(sa * sb);
          {p_hi, p_lo} = pr; left = 32;
        end
        3'd1: begin
          pr = {32'd0, A} * {32'd0, B};
          {p_hi, p_lo} = pr; left = 32;
        end
`ifdef MULT_DIV_UNIT_DIV_EN
        3'd2, 3'd3: begin
          if (B == 32'd0) begin
            p_lo = 32'hFFFF_FFFF; p_hi = A;
          end else if (op == 3'd2) begin
            sa = {{32{A[31]}}, A}; sb = {{32{B[31]}}, B};
            sq = sa / sb; sr = sa % sb;
            p_lo = sq[31:0]; p_hi = sr[31:0];
          end else begin
            p_lo = A / B; p_hi = A % B;
          end
          left = 32;
        end
`endif
        3'd4: m_hi = A;
        3'd5: m_lo = A;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("cyc_busy", 64'(busy), 64'(left > 0));
      check("cyc_done", 64'(done), 64'(m_done));
      check("cyc_hi", 64'(hi), 64'(m_hi));
      check("cyc_lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    start = 1'b1; op = o; A = a; B = b;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; A = $urandom; B = $urandom; op = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (n < 40) begin
      @(posedge clk); #1;
      n++;
      if (done) return;
    end
  endtask

  task automatic run_op(input string name, input logic [2:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el);
    int n;
    issue(o, a, b);
    wait_done(n);
    check({name, "_latency"}, 64'(n), 64'd32);
    check({name, "_hi"}, 64'(hi), 64'(eh));
    check({name, "_lo"}, 64'(lo), 64'(el));
    @(posedge clk); #1;
    check({name, "_done_1cyc"}, 64'(done), 64'd0);
  endtask

  logic [31:0] specials [6] = '{32'd0, 32'd1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd7, 32'h7FFF_FFFF};

  function automatic logic [31:0] pick();
    if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 5)];
    return $urandom;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen, k;
    rst = 1'b1; start = 1'b0; op = 3'd0; A = '0; B = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_hi", 64'(hi), 64'd0);
    check("rst_lo", 64'(lo), 64'd0);
    @(negedge clk); rst = 1'b0;

    run_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE);
    run_op("mult_neg", 3'd0, 32'hFFFF_FFFD, 32'd7, 32'hFFFF_FFFF, 32'hFFFF_FFEB);

    @(negedge clk); start = 1'b1; op = 3'd4; A = 32'h1234;
    @(posedge clk); #1;
    check("mthi_hi", 64'(hi), 64'h1234);
    check("mthi_busy", 64'(busy), 64'd0);
    check("mthi_done", 64'(done), 64'd0);
    @(negedge clk); start = 1'b0;

    issue(3'd6, 32'hDEAD_BEEF, 32'h1);
    repeat (3) @(posedge clk);
    #1;
    check("rsvd_busy", 64'(busy), 64'd0);
    check("rsvd_hi", 64'(hi), 64'h1234);
    check("rsvd_lo", 64'(lo), 64'hFFFF_FFEB);

`ifdef MULT_DIV_UNIT_DIV_EN
    run_op("div_neg", 3'd2, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op("divu", 3'd3, 32'd100, 32'd7, 32'd2, 32'd14);
    run_op("div_zero", 3'd2, 32'd5, 32'd0, 32'd5, 32'hFFFF_FFFF);
    run_op("div_ovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000);
`else
    issue(3'd2, 32'd100, 32'd7);
    #1;
    check("nodiv_busy", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("nodiv_hi", 64'(hi), 64'h1234);
    check("nodiv_lo", 64'(lo), 64'hFFFF_FFEB);
`endif

    // Abort a multiply: restart pulse at iteration 5, reset at iteration 10.
    issue(3'd0, 32'h0001_0003, 32'h0000_0101);
    repeat (4) @(negedge clk);
    start = 1'b1; op = 3'd0;
    @(negedge clk); start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    @(negedge clk); rst = 1'b0;
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (done) seen++;
    end
    check("abort_no_done", 64'(seen), 64'd0);

    for (int i = 0; i < 60; i++) begin
      issue(3'($urandom_range(0, 7)), pick(), pick());
      k = 0;
      while ((left > 0 || m_done) && k < 40) begin
        @(posedge clk); #1;
        k++;
      end
      check("rand_settle", 64'(k < 40), 64'd1);
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
